// File: rtl/shared_ram_arbiter.sv
// rtl/shared_ram_arbiter.sv - round-robin M68K/Z80 arbiter for a single-port synchronous-read shared RAM
module shared_ram_arbiter #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m68k_req,
    input  logic              m68k_rw,
    input  logic [ADDR_W-1:0] m68k_addr,
    input  logic [7:0]        m68k_din,
    output logic [7:0]        m68k_dout,
    output logic              m68k_dtack_n,
    input  logic              z80_req,
    input  logic              z80_wr,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [7:0]        z80_din,
    output logic [7:0]        z80_dout,
    output logic              z80_wait_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);
    typedef enum logic [2:0] {IDLE, M_ACC, M_DATA, Z_ACC, Z_DATA} state_t;

    state_t state, state_nxt;
    logic   last_grant_z;
    logic   m_serviced, z_serviced;
    logic   acc_read, acc_read_nxt;
    logic   m_pending, z_pending;

    assign m_pending  = m68k_req && !m_serviced;
    assign z_pending  = z80_req && !z_serviced;
    assign z80_wait_n = !z_pending;

    // RAM port is only driven in the ACC states; the direction is captured there for DATA
    always_comb begin
        state_nxt    = state;
        acc_read_nxt = acc_read;
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        case (state)
            IDLE: begin
                if (m_pending && (!z_pending || last_grant_z))
                    state_nxt = M_ACC;
                else if (z_pending)
                    state_nxt = Z_ACC;
            end
            M_ACC: begin
                ram_addr     = m68k_addr;
                ram_wdata    = m68k_din;
                ram_we       = !m68k_rw;
                acc_read_nxt = m68k_rw;
                state_nxt    = M_DATA;
            end
            Z_ACC: begin
                ram_addr     = z80_addr;
                ram_wdata    = z80_din;
                ram_we       = z80_wr;
                acc_read_nxt = !z80_wr;
                state_nxt    = Z_DATA;
            end
            M_DATA:  state_nxt = IDLE;
            Z_DATA:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_z <= 1'b1;
            m_serviced   <= 1'b0;
            z_serviced   <= 1'b0;
            acc_read     <= 1'b0;
            m68k_dout    <= '0;
            z80_dout     <= '0;
            m68k_dtack_n <= 1'b1;
        end else begin
            state    <= state_nxt;
            acc_read <= acc_read_nxt;

            if (state == M_DATA) begin
                m_serviced   <= 1'b1;
                last_grant_z <= 1'b0;
                if (acc_read)
                    m68k_dout <= ram_rdata;
            end else if (!m68k_req) begin
                m_serviced <= 1'b0;
            end

            if (state == Z_DATA) begin
                z_serviced   <= 1'b1;
                last_grant_z <= 1'b1;
                if (acc_read)
                    z80_dout <= ram_rdata;
            end else if (!z80_req) begin
                z_serviced <= 1'b0;
            end

            // acknowledge follows the serviced flag as it will be after this edge
            m68k_dtack_n <= !(m68k_req && (m_serviced || state == M_DATA));
        end
    end
endmodule
